// File: rtl/mm_pkg.sv
// Shared types and default sizing for the matrix-multiply BRAM datapath.
package mm_pkg;

    localparam int unsigned MM_W          = 128;
    localparam int unsigned MM_DEPTH      = 1024;
    localparam int unsigned MM_AW         = (MM_DEPTH > 1) ? $clog2(MM_DEPTH) : 1;
    localparam int unsigned MM_RD_LAT     = 2;
    localparam int unsigned MM_FIFO_DEPTH = 4;

    typedef logic [MM_W-1:0]  word_t;
    typedef logic [MM_AW-1:0] addr_t;
    typedef logic [MM_AW:0]   len_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } strm_state_e;

endpackage

// File: rtl/mm_sync_fifo.sv
// Show-ahead synchronous FIFO: head entry is visible whenever not empty.
module mm_sync_fifo #(
    parameter int unsigned W     = 129,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head_c,
    output logic          empty_c,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Pointer increment with explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_c = (count == '0);
    assign do_pop  = pop && !empty_c;
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head_c  = mem[rd_ptr];

    // Storage, pointers and occupancy; storage is cleared so the head reads 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bram_row_streamer.sv
// Strided BRAM reader: issues credit-gated reads and streams the words out with a last marker.
module bram_row_streamer
    import mm_pkg::*;
#(
    parameter int unsigned W          = MM_W,
    parameter int unsigned DEPTH      = MM_DEPTH,
    parameter int unsigned RD_LAT     = MM_RD_LAT,
    parameter int unsigned FIFO_DEPTH = MM_FIFO_DEPTH,
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] stride,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [W-1:0]  mem_dout,
    output logic          m_valid,
    output logic [W-1:0]  m_data,
    output logic          m_last,
    input  logic          m_ready
);

    localparam int unsigned LW  = AW + 1;
    localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

    if (RD_LAT < 1 || FIFO_DEPTH < RD_LAT + 1) begin : g_cfg_check
        $fatal(1, "bram_row_streamer: FIFO_DEPTH must be >= RD_LAT+1 and RD_LAT >= 1");
    end

    strm_state_e    state;
    strm_state_e    state_d;
    logic           done_d;
    logic           mem_en_d;

    logic [AW-1:0]  stride_q;
    logic [LW-1:0]  len_q;
    logic [LW-1:0]  issued;
    logic [LW-1:0]  recv;
    logic [RD_LAT-1:0] vpipe;

    logic [LW-1:0]  sum_c;
    logic [AW-1:0]  next_addr_c;
    logic [CW-1:0]  pipe_cnt_c;
    logic [CW-1:0]  proj_c;
    logic           credit_c;
    logic           issue_last_c;
    logic           push_c;
    logic           push_last_c;
    logic           beat_c;

    logic [W:0]     head_c;
    logic           empty_c;
    logic [FCW-1:0] fifo_count;

    // Output buffer holding {last, data}; reads are only issued when a slot is reserved.
    mm_sync_fifo #(
        .W     (W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_c),
        .push_data ({push_last_c, mem_dout}),
        .pop       (beat_c),
        .head_c    (head_c),
        .empty_c   (empty_c),
        .count     (fifo_count)
    );

    assign m_valid = !empty_c;
    assign m_data  = head_c[W-1:0];
    assign m_last  = head_c[W];
    assign beat_c  = m_valid && m_ready;

    assign push_c       = vpipe[RD_LAT-1];
    assign push_last_c  = (recv == len_q - LW'(1));
    assign issue_last_c = mem_en && (issued == len_q - LW'(1));

    // Next read address with modulo-DEPTH wrap.
    always_comb begin
        sum_c       = {1'b0, mem_addr} + {1'b0, stride_q};
        next_addr_c = (sum_c >= LW'(DEPTH)) ? AW'(sum_c - LW'(DEPTH)) : AW'(sum_c);
    end

    // Credit: words owed to the FIFO next cycle if no new read is issued.
    always_comb begin
        pipe_cnt_c = '0;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            pipe_cnt_c = pipe_cnt_c + CW'(vpipe[i]);
        end
        proj_c   = pipe_cnt_c + CW'(mem_en) + CW'(fifo_count) - CW'(beat_c);
        credit_c = (proj_c < CW'(FIFO_DEPTH));
    end

    // Next-state, done pulse and read-enable decode.
    always_comb begin
        state_d = state;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (issue_last_c) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (beat_c && m_last) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                if (done) begin
                    state_d = IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        mem_en_d = (state_d == ISSUE) && credit_c;
    end

    // Control state and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            mem_en <= 1'b0;
        end else begin
            state  <= state_d;
            busy   <= (state_d != IDLE);
            done   <= done_d;
            mem_en <= mem_en_d;
        end
    end

    // Transfer parameters, address generator and issue/receive counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr <= '0;
            stride_q <= '0;
            len_q    <= '0;
            issued   <= '0;
            recv     <= '0;
        end else if (state == IDLE && start) begin
            mem_addr <= base_addr;
            stride_q <= stride;
            len_q    <= len;
            issued   <= '0;
            recv     <= '0;
        end else begin
            if (mem_en) begin
                mem_addr <= next_addr_c;
                issued   <= issued + LW'(1);
            end
            if (push_c) begin
                recv <= recv + LW'(1);
            end
        end
    end

    // Read-valid pipe tracking BRAM latency; its tail marks mem_dout as capturable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= '0;
        end else begin
            vpipe[0] <= mem_en;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                vpipe[i] <= vpipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_bram_row_streamer.sv
// Bench for bram_row_streamer: BRAM model with mem[i]=i, directed and random transfers.
module tb_bram_row_streamer;

    localparam int unsigned W  = 128;
    localparam int unsigned AW = 10;
    localparam int DEPTH_I     = 1024;
    localparam int FD          = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] stride;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_dout;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic          m_last;
    logic          m_ready;

    logic [W-1:0]  bram [DEPTH_I];
    logic [W-1:0]  rd_q;

    int total;
    int bad;

    bram_row_streamer #(
        .W          (W),
        .DEPTH      (1024),
        .RD_LAT     (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .stride    (stride),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-stage BRAM read: address register then output register.
    always @(posedge clk) begin
        if (mem_en) rd_q <= bram[mem_addr];
        mem_dout <= rd_q;
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always; 1: random ready; 2: ready low in cycles lo_from..lo_to.
    task automatic run_xfer(input int base, input int strd, input int n, input int mode,
                            input int lo_from, input int lo_to, input int poke);
        int exp_addr[$];
        int a;
        int issued;
        int acc;
        int done_cnt;
        int first_v;
        int last_acc;
        int done_cyc;
        int budget;
        a = base;
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(a);
            a = (a + strd) % DEPTH_I;
        end
        issued = 0; acc = 0; done_cnt = 0;
        first_v = -1; last_acc = -1; done_cyc = -1;
        budget = 6 * n + 40;
        base_addr = AW'(base);
        stride    = AW'(strd);
        len       = (AW+1)'(n);
        start     = 1'b1;
        m_ready   = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start = (c == poke);
            if (c == poke) begin
                base_addr = ~base_addr;
                len       = (AW+1)'(5);
            end
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(1, 0));
                default: m_ready = !(c >= lo_from && c <= lo_to);
            endcase
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            check("busy", W'(busy), W'(done_cyc < 0 || c <= done_cyc));
            if (mem_en) begin
                if (issued < n) check("mem_addr", W'(mem_addr), W'(exp_addr[issued]));
                else            check("read_count", W'(issued + 1), W'(n));
                issued++;
            end
            check("credit", W'(issued - acc <= FD), W'(1));
            if (mode == 2 && c == lo_to) check("stall", W'(mem_en), W'(0));
            if (m_valid && first_v < 0) first_v = c;
            if (m_valid && m_ready) begin
                if (acc < n) begin
                    check("m_data", m_data, W'(exp_addr[acc]));
                    check("m_last", W'(m_last), W'(acc == n - 1));
                end else begin
                    check("beat_count", W'(acc + 1), W'(n));
                end
                acc++;
                last_acc = c;
            end
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        check("done_count", W'(done_cnt), W'(1));
        check("issued", W'(issued), W'(n));
        check("accepted", W'(acc), W'(n));
        if (n == 0) begin
            check("done_cycle", W'(done_cyc), W'(2));
            check("valid_seen", W'(first_v >= 0), W'(0));
        end else begin
            check("first_valid", W'(first_v), W'(4));
            check("done_after_last", W'(done_cyc), W'(last_acc + 1));
            if (mode == 0) check("throughput", W'(last_acc), W'(3 + n));
        end
        check("idle_busy", W'(busy), W'(0));
        check("idle_valid", W'(m_valid), W'(0));
    endtask

    initial begin
        int acc;
        total = 0;
        bad   = 0;
        for (int i = 0; i < DEPTH_I; i++) bram[i] = W'(i);
        rd_q      = '0;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        stride    = '0;
        len       = '0;
        m_ready   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",   W'(busy),     W'(0));
        check("rst_done",   W'(done),     W'(0));
        check("rst_mem_en", W'(mem_en),   W'(0));
        check("rst_addr",   W'(mem_addr), W'(0));
        check("rst_valid",  W'(m_valid),  W'(0));
        check("rst_data",   m_data,       W'(0));
        check("rst_last",   W'(m_last),   W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run_xfer(0, 1, 4, 0, 0, 0, -1);
        run_xfer(5, 32, 3, 0, 0, 0, -1);
        run_xfer(1022, 1, 4, 0, 0, 0, -1);
        run_xfer(200, 7, 16, 2, 3, 12, -1);
        run_xfer(0, 0, 0, 0, 0, 0, 1);
        run_xfer(300, 3, 12, 0, 0, 0, 5);

        // Reset in the middle of a transfer.
        base_addr = AW'(40);
        stride    = AW'(3);
        len       = (AW+1)'(8);
        start     = 1'b1;
        m_ready   = 1'b1;
        acc       = 0;
        for (int c = 1; c < 40 && acc < 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (m_valid) acc++;
        end
        check("pre_rst_beats", W'(acc), W'(2));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",   W'(busy),     W'(0));
        check("mid_rst_done",   W'(done),     W'(0));
        check("mid_rst_mem_en", W'(mem_en),   W'(0));
        check("mid_rst_addr",   W'(mem_addr), W'(0));
        check("mid_rst_valid",  W'(m_valid),  W'(0));
        check("mid_rst_data",   m_data,       W'(0));
        check("mid_rst_last",   W'(m_last),   W'(0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_hold_done",  W'(done),    W'(0));
            check("rst_hold_valid", W'(m_valid), W'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_done", W'(done), W'(0));
        run_xfer(100, 1, 2, 0, 0, 0, -1);

        // Randomised transfers, including stride-0 full-depth reads.
        for (int k = 0; k < 8; k++) begin
            run_xfer(int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)),
                     int'($urandom_range(40, 1)), int'($urandom_range(1, 0)), 0, 0, -1);
        end
        run_xfer(int'($urandom_range(1023, 0)), 0, 1024, 1, 0, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
